// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out 8 data bits,
// odd parity and stop bit on device falling edges, then check the device ack.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  input  logic       ps2c_i,
  input  logic       ps2d_i,
  output logic       ps2c_oe_o,
  output logic       ps2d_oe_o,
  output logic       busy_o,
  output logic       tx_done_o,
  output logic       tx_err_o
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned FLT_W   = $clog2(FILTER_LEN + 1);
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_START, S_DATA, S_PARITY, S_STOP, S_ACK, S_WAIT_REL
  } state_t;

  logic [1:0]       c_sync, d_sync;
  logic             c_filt, d_filt, c_filt_q;
  logic [FLT_W-1:0] c_fcnt, d_fcnt;
  logic             fall;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [7:0]       data, data_n;
  logic             par, par_n;
  logic             c_oe, c_oe_n, d_oe, d_oe_n;
  logic             ready, ready_n, busy, busy_n;
  logic             done, done_n, err, err_n;
  logic             timeout;

  // Synchronise the asynchronous pads, then require FILTER_LEN stable samples to change.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c_sync   <= 2'b11;
      d_sync   <= 2'b11;
      c_filt   <= 1'b1;
      d_filt   <= 1'b1;
      c_filt_q <= 1'b1;
      c_fcnt   <= '0;
      d_fcnt   <= '0;
    end else begin
      c_sync   <= {c_sync[0], ps2c_i};
      d_sync   <= {d_sync[0], ps2d_i};
      c_filt_q <= c_filt;
      if (c_sync[1] == c_filt) begin
        c_fcnt <= '0;
      end else if (c_fcnt == FLT_W'(FILTER_LEN - 1)) begin
        c_filt <= c_sync[1];
        c_fcnt <= '0;
      end else begin
        c_fcnt <= c_fcnt + FLT_W'(1);
      end
      if (d_sync[1] == d_filt) begin
        d_fcnt <= '0;
      end else if (d_fcnt == FLT_W'(FILTER_LEN - 1)) begin
        d_filt <= d_sync[1];
        d_fcnt <= '0;
      end else begin
        d_fcnt <= d_fcnt + FLT_W'(1);
      end
    end
  end

  assign fall    = c_filt_q & ~c_filt;
  assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      data  <= '0;
      par   <= 1'b0;
      c_oe  <= 1'b0;
      d_oe  <= 1'b0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      data  <= data_n;
      par   <= par_n;
      c_oe  <= c_oe_n;
      d_oe  <= d_oe_n;
      ready <= ready_n;
      busy  <= busy_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    data_n  = data;
    par_n   = par;
    c_oe_n  = c_oe;
    d_oe_n  = d_oe;
    done_n  = 1'b0;
    err_n   = 1'b0;

    // Device-clocked phase: every falling edge restarts the timeout window.
    if (state inside {S_START, S_DATA, S_PARITY, S_STOP, S_ACK, S_WAIT_REL}) begin
      cnt_n = fall ? '0 : cnt + CNT_W'(1);
      if (!fall && timeout) begin
        state_n = S_IDLE;
        c_oe_n  = 1'b0;
        d_oe_n  = 1'b0;
        err_n   = 1'b1;
      end
    end

    case (state)
      S_IDLE: begin
        c_oe_n = 1'b0;
        d_oe_n = 1'b0;
        if (tx_valid_i && ready) begin
          data_n  = tx_data_i;
          par_n   = ~^tx_data_i;
          cnt_n   = '0;
          c_oe_n  = 1'b1;
          state_n = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
          cnt_n   = '0;
          d_oe_n  = 1'b1;
          state_n = S_RTS;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_RTS: begin
        cnt_n   = '0;
        idx_n   = '0;
        c_oe_n  = 1'b0;
        d_oe_n  = 1'b1;
        state_n = S_START;
      end
      S_START: begin
        if (fall) begin
          d_oe_n  = ~data[0];
          idx_n   = IDX_W'(1);
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (fall) begin
          d_oe_n = ~data[idx];
          idx_n  = idx + IDX_W'(1);
          if (idx == IDX_W'(7)) state_n = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall) begin
          d_oe_n  = ~par;
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          d_oe_n  = 1'b0;
          state_n = S_ACK;
        end
      end
      S_ACK: begin
        if (fall) begin
          if (!d_filt) begin
            state_n = S_WAIT_REL;
          end else begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      S_WAIT_REL: begin
        // A release seen in the timeout cycle still counts as success.
        if (c_filt && d_filt) begin
          err_n   = 1'b0;
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: begin
        c_oe_n  = 1'b0;
        d_oe_n  = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  assign ready_n = (state_n == S_IDLE);
  assign busy_n  = (state_n != S_IDLE);

  assign tx_ready_o = ready;
  assign ps2c_oe_o  = c_oe;
  assign ps2d_oe_o  = d_oe;
  assign busy_o     = busy;
  assign tx_done_o  = done;
  assign tx_err_o   = err;

endmodule
